// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for a common-anode 7-segment bank: internal scan tick, per-slot PWM,
// leading-zero blanking and shadow/active content registers swapped only at frame boundaries.
module sevenseg_scan_driver #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 100_000,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);

    localparam int unsigned SelW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
    localparam logic [SelW-1:0] SelLast = SelW'(NUM_DIGITS - 1);

    logic [PreW-1:0]         presc_q, presc_d;
    logic [SelW-1:0]         sel_q, sel_d;
    logic [PWM_BITS-1:0]     pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, sh_en_q, sh_en_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, act_en_q, act_en_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    logic                    tick, boundary;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lead;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_en, cur_lead, lit;

    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        if (!hex && nib > 4'd9) begin
            g = 7'b1111111;
        end
        return g;
    endfunction

    assign tick     = (presc_q == PreLast);
    assign boundary = tick && (sel_q == SelLast);

    // Scan counters; with a single digit SelLast is 0 so sel never leaves 0.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        pwm_d   = tick ? '0 : pwm_q + 1'b1;
        sel_d   = sel_q;
        if (tick) begin
            sel_d = (sel_q == SelLast) ? '0 : sel_q + 1'b1;
        end
    end

    always_comb begin
        sh_data_d  = load ? data_in : sh_data_q;
        sh_dp_d    = load ? dp_in : sh_dp_q;
        sh_en_d    = load ? digit_en_in : sh_en_q;
        act_data_d = boundary ? sh_data_q : act_data_q;
        act_dp_d   = boundary ? sh_dp_q : act_dp_q;
        act_en_d   = boundary ? sh_en_q : act_en_q;
    end

    // A digit is leading while it and every digit above it show a bare zero.
    always_comb begin
        lead     = '0;
        zero_run = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_data_q[4*i +: 4] == 4'd0) && !act_dp_q[i];
            if (i > 0) begin
                lead[i] = lz_blank && zero_run;
            end
        end
    end

    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_en   = 1'b0;
        cur_lead = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (sel_q == SelW'(i)) begin
                cur_nib  = act_data_q[4*i +: 4];
                cur_dp   = act_dp_q[i];
                cur_en   = act_en_q[i];
                cur_lead = lead[i];
            end
        end
    end

    assign lit = cur_en && !cur_lead && (pwm_q < brightness);

    always_comb begin
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        an_d  = '1;
        fd_d  = boundary;
        if (lit) begin
            seg_d = glyph(cur_nib, hex_mode);
            dp_d  = ~cur_dp;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (sel_q == SelW'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            presc_q    <= '0;
            sel_q      <= '0;
            pwm_q      <= '0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_en_q    <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '0;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
            an_q       <= '1;
            fd_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sel_q      <= sel_d;
            pwm_q      <= pwm_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            sh_en_q    <= sh_en_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    assign segments   = seg_q;
    assign dp         = dp_q;
    assign anodes     = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver (4 digits, 4-cycle slots, 2-bit PWM): a cycle model feeds a
// scoreboard queue, and each scenario also checks the display frame against fixed glyph tables.
module tb_sevenseg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int PB = 2;

    localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0000100, GA = 7'b0001000, GB = 7'b1100000;
    localparam logic [6:0] GC = 7'b0110001, GD = 7'b1000010, GE = 7'b0110000;
    localparam logic [6:0] GF = 7'b0111000, GX = 7'b1111111;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en_in = '0;
    logic        load = 1'b0;
    logic        hex_mode = 1'b0;
    logic        lz_blank = 1'b0;
    logic [1:0]  brightness = '0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anodes;
    logic        frame_done;
    wire  [12:0] obs = {anodes, segments, dp, frame_done};

    int          n_assert = 0;
    int          n_fail = 0;
    logic [12:0] sb[$];
    logic [12:0] exp_v;

    int          m_presc, m_sel, m_pwm;
    logic [15:0] m_sh_d, m_ac_d;
    logic [3:0]  m_sh_dp, m_sh_en, m_ac_dp, m_ac_en;

    sevenseg_scan_driver #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SD),
        .PWM_BITS  (PB)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .digit_en_in(digit_en_in),
        .load       (load),
        .hex_mode   (hex_mode),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .segments   (segments),
        .dp         (dp),
        .anodes     (anodes),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [6:0] ref_glyph(input logic [3:0] n, input logic hex);
        case (n)
            4'h0: return G0;
            4'h1: return G1;
            4'h2: return G2;
            4'h3: return G3;
            4'h4: return G4;
            4'h5: return G5;
            4'h6: return G6;
            4'h7: return G7;
            4'h8: return G8;
            4'h9: return G9;
            4'hA: return hex ? GA : GX;
            4'hB: return hex ? GB : GX;
            4'hC: return hex ? GC : GX;
            4'hD: return hex ? GD : GX;
            4'hE: return hex ? GE : GX;
            default: return hex ? GF : GX;
        endcase
    endfunction

    function automatic logic [12:0] model_out();
        logic       fd, z, lit;
        logic [3:0] nib;
        fd = (m_presc == SD - 1) && (m_sel == ND - 1);
        z  = 1'b1;
        for (int j = m_sel; j < ND; j++) begin
            if (m_ac_d[4*j +: 4] != 4'd0 || m_ac_dp[j]) z = 1'b0;
        end
        nib = m_ac_d[4*m_sel +: 4];
        lit = m_ac_en[m_sel] && (m_pwm < int'(brightness)) && !(lz_blank && z && m_sel != 0);
        if (!lit) return {4'hF, GX, 1'b1, fd};
        return {~(4'b0001 << m_sel), ref_glyph(nib, hex_mode), ~m_ac_dp[m_sel], fd};
    endfunction

    // Reference model: pushes the output expected after each edge, then advances its own state.
    always @(posedge clk_in) begin
        if (reset) begin
            sb.push_back({4'hF, GX, 1'b1, 1'b0});
            m_presc <= 0;
            m_sel   <= 0;
            m_pwm   <= 0;
            m_sh_d  <= '0;
            m_sh_dp <= '0;
            m_sh_en <= '0;
            m_ac_d  <= '0;
            m_ac_dp <= '0;
            m_ac_en <= '0;
        end else begin
            sb.push_back(model_out());
            m_presc <= (m_presc == SD - 1) ? 0 : m_presc + 1;
            m_pwm   <= (m_presc == SD - 1) ? 0 : (m_pwm + 1) % (1 << PB);
            if (m_presc == SD - 1) m_sel <= (m_sel + 1) % ND;
            if (load) begin
                m_sh_d  <= data_in;
                m_sh_dp <= dp_in;
                m_sh_en <= digit_en_in;
            end
            if (m_presc == SD - 1 && m_sel == ND - 1) begin
                m_ac_d  <= m_sh_d;
                m_ac_dp <= m_sh_dp;
                m_ac_en <= m_sh_en;
            end
        end
    end

    // Expected output for position k of a frame that starts right after a frame_done pulse.
    function automatic logic [12:0] slot_exp(int k, logic [27:0] gl, logic [3:0] en,
                                             logic [3:0] dpv, int br);
        int   d  = k / 4;
        int   p  = k % 4;
        logic fd = (k == 15);
        if (en[d] && p < br) return {~(4'b0001 << d), gl[7*d +: 7], ~dpv[d], fd};
        return {4'hF, GX, 1'b1, fd};
    endfunction

    task automatic step();
        @(negedge clk_in);
        if (sb.size() > 0) exp_v = sb.pop_front();
        else exp_v = 'x;
    endtask

    task automatic sync_frame(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = (frame_done === 1'b1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk_in);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            n_assert++;
            if (obs !== {4'hF, GX, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_values got %b expected %b", obs, {4'hF, GX, 1'b1, 1'b0});
            end
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_model got %b expected %b", obs, exp_v);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bit          found = 1'b0;
        logic [12:0] want;
        data_in = 16'h12A4; digit_en_in = 4'hF; dp_in = 4'h0;
        hex_mode = 1'b1; lz_blank = 1'b0; brightness = 2'd3; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            n_assert++;
            if (anodes !== 4'hF) begin
                n_fail++;
                $display("FAIL basic_dark_before_frame got %b expected 1111", anodes);
            end
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL basic_dark_model got %b expected %b", obs, exp_v);
            end
            found = (frame_done === 1'b1);
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL basic_first_frame got no frame_done expected pulse within 40 cycles");
        end
        for (int k = 0; k < 32; k++) begin
            step();
            want = slot_exp(k % 16, {G1, G2, GA, G4}, 4'hF, 4'h0, 3);
            n_assert++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL basic_scan k=%0d got %b expected %b", k, obs, want);
            end
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL basic_model k=%0d got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_lz_blank();
        bit          found;
        logic [12:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            lz_blank = 1'b1; data_in = 16'h0050; digit_en_in = 4'hF;
            dp_in = (pass == 0) ? 4'b0000 : 4'b1000;
            load = 1'b1;
            step();
            load = 1'b0;
            sync_frame(found);
            n_assert++;
            if (!found) begin
                n_fail++;
                $display("FAIL lz_sync pass=%0d got no frame_done expected pulse", pass);
            end
            for (int k = 0; k < 16; k++) begin
                step();
                want = (pass == 0) ? slot_exp(k, {G0, G0, G5, G0}, 4'b0011, 4'b0000, 3)
                                   : slot_exp(k, {G0, G0, G5, G0}, 4'b1111, 4'b1000, 3);
                n_assert++;
                if (obs !== want) begin
                    n_fail++;
                    $display("FAIL lz_scan pass=%0d k=%0d got %b expected %b", pass, k, obs, want);
                end
                n_assert++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL lz_model pass=%0d k=%0d got %b expected %b", pass, k, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_hex_off();
        bit          found;
        logic [12:0] want;
        hex_mode = 1'b0; lz_blank = 1'b0; dp_in = 4'h0; data_in = 16'h000B; load = 1'b1;
        step();
        load = 1'b0;
        sync_frame(found);
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL hex_sync got no frame_done expected pulse");
        end
        for (int k = 0; k < 16; k++) begin
            step();
            want = slot_exp(k, {G0, G0, G0, GX}, 4'hF, 4'h0, 3);
            n_assert++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL hex_off_scan k=%0d got %b expected %b", k, obs, want);
            end
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL hex_off_model k=%0d got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_midframe_load();
        logic [12:0] want;
        logic [27:0] gl;
        for (int f = 0; f < 4; f++) begin
            case (f)
                0:       gl = {G0, G0, G0, GX};
                1, 2:    gl = {G8, G7, G6, G5};
                default: gl = {G9, GE, G0, GC};
            endcase
            for (int k = 0; k < 16; k++) begin
                if (f == 0 && k == 4) begin
                    data_in = 16'h8765; load = 1'b1;
                end
                if (f == 0 && k == 5) load = 1'b0;
                if (f == 1 && k == 15) begin
                    data_in = 16'h9E0C; load = 1'b1;
                end
                step();
                want = slot_exp(k, gl, 4'hF, 4'h0, 3);
                n_assert++;
                if (obs !== want) begin
                    n_fail++;
                    $display("FAIL midframe_scan f=%0d k=%0d got %b expected %b", f, k, obs, want);
                end
                n_assert++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL midframe_model f=%0d k=%0d got %b expected %b", f, k, obs, exp_v);
                end
            end
            load = 1'b0;
            hex_mode = 1'b1;
        end
    endtask

    task automatic test_brightness();
        logic [12:0] want;
        for (int b = 0; b < 2; b++) begin
            brightness = 2'(b);
            for (int k = 0; k < 16; k++) begin
                step();
                want = slot_exp(k, {G9, GE, G0, GC}, 4'hF, 4'h0, b);
                n_assert++;
                if (obs !== want) begin
                    n_fail++;
                    $display("FAIL brightness_scan b=%0d k=%0d got %b expected %b", b, k, obs, want);
                end
                n_assert++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL brightness_model b=%0d k=%0d got %b expected %b", b, k, obs, exp_v);
                end
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_reset_midframe();
        bit          found;
        logic [12:0] want;
        repeat (8) step();
        reset = 1'b1;
        step();
        n_assert++;
        if (obs !== {4'hF, GX, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_values got %b expected %b", obs, {4'hF, GX, 1'b1, 1'b0});
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            n_assert++;
            if (anodes !== 4'hF) begin
                n_fail++;
                $display("FAIL midreset_dark i=%0d got %b expected 1111", i, anodes);
            end
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL midreset_model i=%0d got %b expected %b", i, obs, exp_v);
            end
        end
        data_in = 16'h1234; digit_en_in = 4'hF; dp_in = 4'h0; load = 1'b1;
        step();
        load = 1'b0;
        sync_frame(found);
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL midreset_sync got no frame_done expected pulse");
        end
        for (int k = 0; k < 16; k++) begin
            step();
            want = slot_exp(k, {G1, G2, G3, G4}, 4'hF, 4'h0, 3);
            n_assert++;
            if (obs !== want) begin
                n_fail++;
                $display("FAIL midreset_scan k=%0d got %b expected %b", k, obs, want);
            end
            n_assert++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL midreset_model_lit k=%0d got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz_blank();
        test_hex_off();
        test_midframe_load();
        test_brightness();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
